pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the fetch stage: owns the fetch PC and drives the `pc_i` input of `fetch`. It tracks a valid bit and PC for the instruction word `fetch` holds in its register. It applies hazard stalls, branch/jump redirects and halt/resume requests with a fixed priority. It sits between execute/decode control and `fetch`, with no memory interface of its own.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `conflict_i`  in  1  hazard stall, the same signal that drives `fetch.conflict_i`.
- `redirect_i`  in  1  taken branch/jump from execute.
- `redirect_pc_i`  in  32  redirect target.
- `halt_i`  in  1  level halt request (ecall/ebreak/debug).
- `resume_i`  in  1  leave HALT.
- `pc_o`  out  32  fetch address, registered; connects to `fetch.pc_i`.
- `inst_pc_o`  out  32  PC of the word currently in `fetch.inst_o`.
- `inst_valid_o`  out  1  `fetch.inst_o` holds a correct-path instruction.
- `flush_o`  out  1  combinational; kill the instruction downstream of fetch this cycle.
- `misalign_o`  out  1  one-cycle pulse: the last accepted redirect target had bits [1:0] ≠ 0.
- `halted_o`  out  1  state is HALT.

## Operation
- States:
  - BOOT: one cycle after reset deasserts; nothing is fetched.
  - RUN: normal fetching.
  - HALT: PC frozen.
- Reset (while `rst_i` = 1):
  - `pc_o` = RESET_PC, `inst_pc_o` = 0.
  - `inst_valid_o` = 0, `misalign_o` = 0, `halted_o` = 0.
  - state = BOOT.
  - `flush_o` forced 0.
  - Reset asserted mid-operation overrides every request in that cycle.
- BOOT → RUN unconditionally. `pc_o` is unchanged; `inst_valid_o` stays 0.
- RUN, per cycle, in priority order:
  1. `redirect_i`:
     - `pc_o` ← {redirect_pc_i[31:2], 2'b00}.
     - `inst_valid_o` ← 0, because the word being fetched is wrong-path.
     - `flush_o` = 1 in the same cycle.
     - `misalign_o` ← |redirect_pc_i[1:0].
     - Overrides `conflict_i`.
     - If `halt_i` is also high and `conflict_i` is low, the next state is HALT, with the redirected PC.
  2. `halt_i` with `conflict_i` = 0:
     - Next state HALT.
     - `pc_o` held, so the word at `pc_o` is refetched after resume.
     - `inst_valid_o` ← 0.
  3. `conflict_i`: `pc_o`, `inst_pc_o` and `inst_valid_o` all hold. `halt_i` is deferred, not dropped.
  4. Otherwise: `inst_pc_o` ← `pc_o`, `inst_valid_o` ← 1, `pc_o` ← `pc_o` + 4.
- HALT:
  - `halted_o` = 1 and `inst_valid_o` = 0.
  - `pc_o` holds, except that `redirect_i` loads a new target (debug set-PC). The state stays HALT and `flush_o` = 1.
  - `resume_i` → RUN on the next edge. `halt_i` is ignored in HALT.
  - `conflict_i` is ignored in HALT.
- `resume_i` is ignored outside HALT.
- `misalign_o` is 0 on every cycle not following a redirect.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- `pc_o` is a register. The instruction memory returns data combinationally and `fetch` registers it. So a word fetched at `pc_o` in cycle N appears in `inst_o`, with `inst_pc_o`/`inst_valid_o`, in cycle N+1.
- First valid instruction: cycle 2 after reset deassertion (BOOT is cycle 0, the first RUN fetch is cycle 1).
- Redirect in cycle N:
  - `flush_o` is high in cycle N.
  - `inst_valid_o` is 0 in N+1.
  - The target word is valid in N+2, a two-cycle bubble.
- Halt accepted in cycle N: `halted_o` = 1 from N+1.
- Resume in cycle M: RUN in M+1, with the refetched word valid in M+2.

## Configuration
- `PC_SEQ_PERF_EN` defined:
  - Adds outputs `fetch_cnt_o` [31:0] and `stall_cnt_o` [31:0].
  - `fetch_cnt_o` increments on each RUN cycle with no redirect, no halt accepted and no conflict.
  - `stall_cnt_o` increments on each RUN cycle with `conflict_i` = 1 and no redirect.
  - Both reset to 0 and wrap at 2^32.
- `PC_SEQ_PERF_EN` undefined: neither the ports nor the counters exist; all other behaviour is identical.

## Test plan
- Reset with RESET_PC = 32'h100, then release, no requests → `pc_o` = 100, 100, 104, 108 over cycles 0–3. `inst_valid_o` goes 1 at cycle 2 with `inst_pc_o` = 100.
- Stall: `conflict_i` high for 3 cycles while at `pc_o` = 108 → `pc_o`/`inst_pc_o`/`inst_valid_o` frozen for those 3 cycles, then `pc_o` = 10C. With PERF, `stall_cnt_o` = 3.
- Redirect to 32'h2002 while `conflict_i` = 1 → `flush_o` = 1 in the same cycle. Next cycle: `pc_o` = 2000, `misalign_o` = 1, `inst_valid_o` = 0. Following cycle: `inst_pc_o` = 2000, valid.
- `halt_i` asserted with `conflict_i` high for 2 cycles, then `conflict_i` low → HALT is entered only after conflict clears, with `pc_o` held. Then redirect 32'h400 in HALT, then `resume_i` → the first valid `inst_pc_o` = 400.
- Wrap: redirect to 32'hFFFF_FFFC, then run → `pc_o` = FFFF_FFFC then 0.
- `rst_i` asserted mid-run while redirect and halt are high → next cycle `pc_o` = RESET_PC, state BOOT, `flush_o` = 0, all outputs at reset values.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: BOOT/RUN/HALT control of the fetch PC,
// with stall, redirect and halt/resume handling. Optional counters under PC_SEQ_PERF_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        conflict_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    input  logic        resume_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic        halted_o
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;
    logic        r_misalign;

    logic [31:0] w_target;
    logic        w_misalign;
    logic        w_halt_take;

    assign w_target    = {redirect_pc_i[31:2], 2'b00};
    assign w_misalign  = |redirect_pc_i[1:0];
    // A halt request waits until the hazard stall clears.
    assign w_halt_take = halt_i & ~conflict_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= StBoot;
            r_pc         <= RESET_PC;
            r_inst_pc    <= 32'h0;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            unique case (r_state)
                StBoot: begin
                    r_state      <= StRun;
                    r_inst_valid <= 1'b0;
                end
                StRun: begin
                    if (redirect_i) begin
                        r_pc         <= w_target;
                        r_inst_valid <= 1'b0;
                        r_misalign   <= w_misalign;
                        if (w_halt_take) begin
                            r_state <= StHalt;
                        end
                    end else if (w_halt_take) begin
                        r_state      <= StHalt;
                        r_inst_valid <= 1'b0;
                    end else if (!conflict_i) begin
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_pc         <= r_pc + 32'd4;
                    end
                end
                StHalt: begin
                    r_inst_valid <= 1'b0;
                    if (redirect_i) begin
                        r_pc       <= w_target;
                        r_misalign <= w_misalign;
                    end
                    if (resume_i) begin
                        r_state <= StRun;
                    end
                end
                default: begin
                    r_state      <= StBoot;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o         = r_pc;
    assign inst_pc_o    = r_inst_pc;
    assign inst_valid_o = r_inst_valid;
    assign misalign_o   = r_misalign;
    assign halted_o     = (r_state == StHalt);
    assign flush_o      = ~rst_i & redirect_i & ((r_state == StRun) | (r_state == StHalt));

`ifdef PC_SEQ_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_cnt <= 32'h0;
            r_stall_cnt <= 32'h0;
        end else if (r_state == StRun && !redirect_i) begin
            if (conflict_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else if (!halt_i) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues the expected outputs of
// each cycle, and a negedge monitor pops and compares them against the DUT.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        conflict_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        resume_i;
    logic [31:0] pc_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        flush_o;
    logic        misalign_o;
    logic        halted_o;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .conflict_i   (conflict_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .halt_i       (halt_i),
        .resume_i     (resume_i),
        .pc_o         (pc_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .flush_o      (flush_o),
        .misalign_o   (misalign_o),
        .halted_o     (halted_o)
`ifdef PC_SEQ_PERF_EN
        ,
        .fetch_cnt_o  (fetch_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic        iv;
        logic        mis;
        logic        halted;
        logic        flush;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;

    // Reference model: mode 0 = boot, 1 = run, 2 = halt.
    int          m_mode;
    logic [31:0] m_pc, m_ipc, m_fc, m_sc;
    logic        m_iv, m_mis;

    task automatic model_reset();
        m_mode = 0;
        m_pc   = RST_PC;
        m_ipc  = 0;
        m_iv   = 0;
        m_mis  = 0;
        m_fc   = 0;
        m_sc   = 0;
    endtask

    // Apply one cycle of inputs: queue this cycle's expected outputs, advance the model, clock.
    task automatic step(input logic rst, input logic conf, input logic redir,
                        input logic [31:0] rpc, input logic halt, input logic res);
        exp_t e;
        rst_i = rst; conflict_i = conf; redirect_i = redir;
        redirect_pc_i = rpc; halt_i = halt; resume_i = res;
        e.pc = m_pc; e.ipc = m_ipc; e.iv = m_iv; e.mis = m_mis;
        e.halted = (m_mode == 2);
        e.flush  = !rst && redir && (m_mode != 0);
        e.fc = m_fc; e.sc = m_sc;
        sb.push_back(e);
        if (rst) begin
            model_reset();
        end else begin
            m_mis = 0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (redir) begin
                    m_pc  = rpc & ~32'd3;
                    m_iv  = 0;
                    m_mis = (rpc % 4) != 0;
                    if (halt && !conf) m_mode = 2;
                end else if (halt && !conf) begin
                    m_mode = 2;
                    m_iv   = 0;
                end else if (conf) begin
                    m_sc = m_sc + 1;
                end else begin
                    m_ipc = m_pc;
                    m_iv  = 1;
                    m_pc  = m_pc + 4;
                    m_fc  = m_fc + 1;
                end
            end else begin
                if (redir) begin
                    m_pc  = rpc & ~32'd3;
                    m_mis = (rpc % 4) != 0;
                end
                if (res) m_mode = 1;
            end
        end
        @(posedge clk_i);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                chk("pc_o", pc_o, e.pc);
                chk("inst_pc_o", inst_pc_o, e.ipc);
                chk("inst_valid_o", {31'b0, inst_valid_o}, {31'b0, e.iv});
                chk("misalign_o", {31'b0, misalign_o}, {31'b0, e.mis});
                chk("halted_o", {31'b0, halted_o}, {31'b0, e.halted});
                chk("flush_o", {31'b0, flush_o}, {31'b0, e.flush});
`ifdef PC_SEQ_PERF_EN
                chk("fetch_cnt_o", fetch_cnt_o, e.fc);
                chk("stall_cnt_o", stall_cnt_o, e.sc);
`endif
            end
        end
    end

    initial begin : stimulus
        logic [31:0] rpc;
        logic        r, c, d, h, s;
        rst_i = 1; conflict_i = 0; redirect_i = 0; redirect_pc_i = 0; halt_i = 0; resume_i = 0;
        model_reset();
        @(posedge clk_i);
        #1;
        step(1, 0, 0, 32'h0, 0, 0);
        // Boot and straight-line fetch up to pc 0x108.
        idle(3);
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        idle(1);
        // Misaligned redirect while stalled.
        step(0, 1, 1, 32'h0000_2002, 0, 0);
        idle(2);
        // Halt deferred by conflict, then debug set-PC and resume.
        step(0, 1, 0, 32'h0, 1, 0);
        step(0, 1, 0, 32'h0, 1, 0);
        step(0, 0, 0, 32'h0, 1, 0);
        step(0, 1, 0, 32'h0, 1, 0);
        step(0, 0, 1, 32'h0000_0400, 0, 0);
        step(0, 0, 0, 32'h0, 0, 1);
        idle(3);
        // Address wrap.
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        idle(3);
        // Reset wins over redirect and halt.
        step(1, 0, 1, 32'h0000_0800, 1, 0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 3) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(r, c, d, rpc, h, s);
        end
        idle(2);
        @(negedge clk_i);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
